// File: rtl/rv32i_wb_queue.sv
// RV32I writeback stage: source select, load align/extend, and a small write queue
// draining into the register file, with youngest-first forwarding over pending writes.
module rv32i_wb_queue #(
  parameter int                NSRC      = 3,
  parameter int                DEPTH     = 2,
  parameter logic [NSRC-1:0]   LOAD_MASK = NSRC'(3'b011),
  parameter int                SELW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       wb_en_in,
  input  logic [4:0]                 wb_reg_in,
  input  logic [2:0]                 funct3_in,
  input  logic [1:0]                 addr_lo_in,
  input  logic [SELW-1:0]            src_sel_in,
  input  logic [NSRC*32-1:0]         src_data_in,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  input  logic                       rf_ready,
  input  logic [4:0]                 df_query_reg,
  output logic                       df_hit,
  output logic [31:0]                df_data,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCCW = $clog2(DEPTH) + 1;

  function automatic logic [31:0] align(input logic [31:0] d, input logic [2:0] f3,
                                        input logic [1:0] alo);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{alo, 3'b000} +: 8];
    h = alo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  logic [31:0]     src_val [NSRC];
  logic [31:0]     sel_data;
  logic [4:0]      wreg_q  [DEPTH];
  logic [31:0]     wdata_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCCW-1:0] occ_q, occ_d;
  logic            accept, push, pop;
  logic [DEPTH-1:0] fwd_match;
  logic [31:0]     fwd_data [DEPTH];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [31:0] raw;
    assign raw         = src_data_in[32*gi +: 32];
    assign src_val[gi] = LOAD_MASK[gi] ? align(raw, funct3_in, addr_lo_in) : raw;
  end

  // Out-of-range selects fall through to the ALU source.
  always_comb begin
    sel_data = src_val[NSRC-1];
    for (int i = 0; i < NSRC; i++) begin
      if ({1'b0, src_sel_in} == (SELW+1)'(i)) sel_data = src_val[i];
    end
  end

  assign in_ready = !reset && (occ_q < OCCW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && wb_en_in && (wb_reg_in != 5'd0);
  assign rf_we    = (occ_q != '0);
  assign pop      = rf_we && rf_ready;
  assign rf_waddr = rf_we ? wreg_q[head_q]  : 5'd0;
  assign rf_wdata = rf_we ? wdata_q[head_q] : 32'd0;
  assign occupancy = occ_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop)  head_d = head_q + PTRW'(1);
    if (push) tail_d = tail_q + PTRW'(1);
    if (push && !pop)      occ_d = occ_q + OCCW'(1);
    else if (pop && !push) occ_d = occ_q - OCCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      wreg_q[tail_q]  <= wb_reg_in;
      wdata_q[tail_q] <= sel_data;
    end
  end

  // Index gi is age from the head, so higher gi is younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    logic [PTRW-1:0] slot;
    assign slot          = head_q + PTRW'(gi);
    assign fwd_match[gi] = (OCCW'(gi) < occ_q) && (wreg_q[slot] == df_query_reg);
    assign fwd_data[gi]  = wdata_q[slot];
  end

  always_comb begin
    df_hit  = 1'b0;
    df_data = 32'd0;
    if (df_query_reg != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fwd_match[i]) begin
          df_hit  = 1'b1;
          df_data = fwd_data[i];
        end
      end
    end
  end
endmodule
